// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: the pipeline writeback always wins,
// and mult/div results queue in a small FIFO that drains into idle cycles.
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wbValid,
    input  logic [4:0]    wbReg,
    input  logic [31:0]   wbData,
    input  logic          mdValid,
    input  logic [4:0]    mdReg,
    input  logic [31:0]   mdData,
    output logic          mdReady,
    input  logic [4:0]    readReg1,
    input  logic [4:0]    readReg2,
    output logic          pendingHit1,
    output logic          pendingHit2,
    output logic          regWrite,
    output logic [4:0]    writeReg,
    output logic [31:0]   writeData,
    output logic          stallPipe,
    output logic [CW-1:0] fifoCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       slot_reg  [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] valid_next;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;
    logic [SW-1:0]    starve_next;
    logic             stall;
    logic             wb_grant;
    logic             enq;
    logic             deq;
    logic             hit1;
    logic             hit2;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mdReady   = (count < CW'(DEPTH)) && !reset;
    assign wb_grant  = wbValid && (wbReg != 5'd0);
    // Only registered occupancy can drain, so a fresh entry waits a cycle.
    assign deq       = !reset && !wb_grant && (count != '0);
    // Writes to x0 complete the handshake but are dropped here.
    assign enq       = mdValid && mdReady && (mdReg != 5'd0);
    assign fifoCount = count;
    assign stallPipe = stall;

    always_comb begin
        regWrite  = 1'b0;
        writeReg  = 5'd0;
        writeData = 32'd0;
        if (!reset) begin
            if (wb_grant) begin
                regWrite  = 1'b1;
                writeReg  = wbReg;
                writeData = wbData;
            end else if (count != '0) begin
                regWrite  = 1'b1;
                writeReg  = slot_reg[head];
                writeData = slot_data[head];
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_reg[i] == readReg1)) hit1 = 1'b1;
            if (slot_valid[i] && (slot_reg[i] == readReg2)) hit2 = 1'b1;
        end
    end

    assign pendingHit1 = hit1 && (readReg1 != 5'd0);
    assign pendingHit2 = hit2 && (readReg2 != 5'd0);

    always_comb begin
        valid_next = slot_valid;
        if (deq) valid_next[head] = 1'b0;
        if (enq) valid_next[tail] = 1'b1;
    end

    always_comb begin
        if ((count == '0) || deq) begin
            starve_next = '0;
        end else if (starve != SW'(STARVE_LIMIT)) begin
            starve_next = starve + 1'b1;
        end else begin
            starve_next = starve;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve     <= '0;
            stall      <= 1'b0;
            slot_valid <= '0;
        end else begin
            if (enq) begin
                slot_reg[tail]  <= mdReg;
                slot_data[tail] <= mdData;
                tail            <= wrap_inc(tail);
            end
            if (deq) head <= wrap_inc(head);
            slot_valid <= valid_next;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            starve <= starve_next;
            if (deq) begin
                stall <= 1'b0;
            end else if (starve_next == SW'(STARVE_LIMIT)) begin
                stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbValid;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        mdValid;
    logic [4:0]  mdReg;
    logic [31:0] mdData;
    logic        mdReady;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        pendingHit1;
    logic        pendingHit2;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        stallPipe;
    logic [2:0]  fifoCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .CW(3)) dut (
        .clk(clk), .reset(reset),
        .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData),
        .mdValid(mdValid), .mdReg(mdReg), .mdData(mdData),
        .mdReady(mdReady),
        .readReg1(readReg1), .readReg2(readReg2),
        .pendingHit1(pendingHit1), .pendingHit2(pendingHit2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .stallPipe(stallPipe), .fifoCount(fifoCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; wbValid = 1'b0; wbReg = '0; wbData = '0;
        mdValid = 1'b0; mdReg = '0; mdData = '0;
        readReg1 = '0; readReg2 = '0;
        tick();
        #1;
        check("rst_mdReady", 32'(mdReady), 32'd0);
        check("rst_regWrite", 32'(regWrite), 32'd0);
        tick();
        check("rst_count", 32'(fifoCount), 32'd0);
        check("rst_stall", 32'(stallPipe), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_mdReady", 32'(mdReady), 32'd1);

        // Idle port pass-through
        mdValid = 1'b1; mdReg = 5'd5; mdData = 32'hDEADBEEF;
        #1;
        check("pt_no_same_cycle", 32'(regWrite), 32'd0);
        tick();
        mdValid = 1'b0;
        #1;
        check("pt_regWrite", 32'(regWrite), 32'd1);
        check("pt_writeReg", 32'(writeReg), 32'd5);
        check("pt_writeData", writeData, 32'hDEADBEEF);
        check("pt_count1", 32'(fifoCount), 32'd1);
        tick();
        check("pt_count0", 32'(fifoCount), 32'd0);
        check("pt_idle", 32'(regWrite), 32'd0);

        // Priority: pipeline beats a queued entry
        wbValid = 1'b1; wbReg = 5'd3; wbData = 32'h22;
        mdValid = 1'b1; mdReg = 5'd7; mdData = 32'h11;
        tick();
        mdValid = 1'b0;
        #1;
        check("pri_count", 32'(fifoCount), 32'd1);
        check("pri_wbReg", 32'(writeReg), 32'd3);
        check("pri_wbData", writeData, 32'h22);
        tick();
        wbValid = 1'b0;
        #1;
        check("pri_drainReg", 32'(writeReg), 32'd7);
        check("pri_drainData", writeData, 32'h11);
        tick();
        check("pri_empty", 32'(fifoCount), 32'd0);

        // Full / backpressure / hazards
        wbValid = 1'b1; wbReg = 5'd3; wbData = 32'h33;
        mdValid = 1'b1; mdReg = 5'd7; mdData = 32'h70;
        tick();
        mdReg = 5'd9; mdData = 32'h90;
        tick();
        mdReg = 5'd12; mdData = 32'hC0;
        readReg1 = 5'd7; readReg2 = 5'd9;
        #1;
        check("full_count", 32'(fifoCount), 32'd2);
        check("full_mdReady", 32'(mdReady), 32'd0);
        check("hit1_7", 32'(pendingHit1), 32'd1);
        check("hit2_9", 32'(pendingHit2), 32'd1);
        tick();
        readReg1 = 5'd0; readReg2 = 5'd12;
        #1;
        check("held_count", 32'(fifoCount), 32'd2);
        check("hit1_r0", 32'(pendingHit1), 32'd0);
        check("hit2_12", 32'(pendingHit2), 32'd0);
        wbValid = 1'b0; readReg1 = 5'd7;
        #1;
        check("drain7_reg", 32'(writeReg), 32'd7);
        check("drain7_data", writeData, 32'h70);
        check("drain7_mdReady", 32'(mdReady), 32'd0);
        check("drain7_hit", 32'(pendingHit1), 32'd1);
        tick();
        check("drain9_reg", 32'(writeReg), 32'd9);
        check("drain9_mdReady", 32'(mdReady), 32'd1);
        check("drain9_hit7", 32'(pendingHit1), 32'd0);
        tick();
        mdValid = 1'b0;
        #1;
        check("drain12_reg", 32'(writeReg), 32'd12);
        check("drain12_data", writeData, 32'hC0);
        check("drain12_count", 32'(fifoCount), 32'd1);
        tick();
        check("bp_empty", 32'(fifoCount), 32'd0);
        check("bp_stall", 32'(stallPipe), 32'd0);

        // Starvation
        wbValid = 1'b1; wbReg = 5'd3; wbData = 32'h33;
        mdValid = 1'b1; mdReg = 5'd4; mdData = 32'h44;
        tick();
        mdValid = 1'b0;
        #1;
        check("st_count", 32'(fifoCount), 32'd1);
        check("st_stall0", 32'(stallPipe), 32'd0);
        tick();
        check("st_stall1", 32'(stallPipe), 32'd0);
        tick();
        check("st_stall2", 32'(stallPipe), 32'd0);
        tick();
        check("st_stall3", 32'(stallPipe), 32'd0);
        tick();
        wbValid = 1'b0;
        #1;
        check("st_stall4", 32'(stallPipe), 32'd1);
        check("st_drain_reg", 32'(writeReg), 32'd4);
        check("st_drain_data", writeData, 32'h44);
        tick();
        check("st_cleared", 32'(stallPipe), 32'd0);
        check("st_empty", 32'(fifoCount), 32'd0);

        // Zero register
        mdValid = 1'b1; mdReg = 5'd0; mdData = 32'h99;
        #1;
        check("z_mdReady", 32'(mdReady), 32'd1);
        tick();
        mdValid = 1'b0;
        #1;
        check("z_count", 32'(fifoCount), 32'd0);
        check("z_noWrite", 32'(regWrite), 32'd0);
        wbValid = 1'b1; wbReg = 5'd3; wbData = 32'h33;
        mdValid = 1'b1; mdReg = 5'd6; mdData = 32'h66;
        tick();
        mdValid = 1'b0; wbReg = 5'd0; wbData = 32'h55;
        #1;
        check("wb0_drain_reg", 32'(writeReg), 32'd6);
        check("wb0_drain_data", writeData, 32'h66);
        tick();
        check("wb0_empty", 32'(fifoCount), 32'd0);

        // Reset mid-operation
        wbReg = 5'd3; wbData = 32'h33;
        mdValid = 1'b1; mdReg = 5'd10; mdData = 32'hA;
        tick();
        mdReg = 5'd11; mdData = 32'hB;
        tick();
        mdValid = 1'b0;
        #1;
        check("mr_count2", 32'(fifoCount), 32'd2);
        reset = 1'b1; wbValid = 1'b0;
        #1;
        check("mr_mdReady", 32'(mdReady), 32'd0);
        check("mr_regWrite", 32'(regWrite), 32'd0);
        tick();
        reset = 1'b0; readReg1 = 5'd10; readReg2 = 5'd11;
        #1;
        check("mr_count0", 32'(fifoCount), 32'd0);
        check("mr_stall", 32'(stallPipe), 32'd0);
        check("mr_noWrite", 32'(regWrite), 32'd0);
        check("mr_hit1", 32'(pendingHit1), 32'd0);
        check("mr_hit2", 32'(pendingHit2), 32'd0);
        tick();
        check("mr_noWrite2", 32'(regWrite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
